// File: rtl/clock_set_controller.sv
// clock_set_controller: mode/inc/dec/cancel editor that loads a BCD hh:mm:ss value into a 24-hour clock
module clock_set_controller (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mode,
  input  logic        inc,
  input  logic        dec,
  input  logic        cancel,
  input  logic [23:0] time_out,
  output logic        set_time,
  output logic [23:0] time_in,
  output logic        editing,
  output logic [1:0]  edit_field
);
  typedef enum logic [2:0] {RUN, SET_HR, SET_MIN, SET_SEC, LOAD} state_t;
  state_t      state_q, state_d;
  logic [23:0] edit_q, edit_d;
  logic [7:0]  fld, fld_max, fld_new;
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] mx, input logic up);
    if (up) return v == mx ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    return v == 8'h00 ? mx : v[3:0] == 4'd0 ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
  endfunction
  always_comb begin
    fld     = state_q == SET_HR ? edit_q[23:16] : state_q == SET_MIN ? edit_q[15:8] : edit_q[7:0];
    fld_max = state_q == SET_HR ? 8'h23 : 8'h59;
    fld_new = bcd_step(fld, fld_max, inc);
    state_d = state_q;
    edit_d  = edit_q;
    case (state_q)
      RUN: if (mode) begin
        state_d = SET_HR;
        edit_d  = time_out;
      end
      LOAD: state_d = RUN;
      default:
        if (cancel) state_d = RUN;
        else if (mode) state_d = state_q == SET_HR ? SET_MIN : state_q == SET_MIN ? SET_SEC : LOAD;
        else if (inc ^ dec)
          edit_d = state_q == SET_HR  ? {fld_new, edit_q[15:0]} :
                   state_q == SET_MIN ? {edit_q[23:16], fld_new, edit_q[7:0]} :
                                        {edit_q[23:8], fld_new};
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= RUN;
      edit_q  <= 24'h000000;
    end else begin
      state_q <= state_d;
      edit_q  <= edit_d;
    end
  assign set_time   = state_q == LOAD;
  assign editing    = state_q == SET_HR || state_q == SET_MIN || state_q == SET_SEC;
  assign edit_field = editing ? state_q[1:0] : 2'd0;
  assign time_in    = edit_q;
endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller: directed vectors with hand-computed expectations for clock_set_controller
module tb_clock_set_controller;
  logic        clk = 0, reset_n = 0, mode = 0, inc = 0, dec = 0, cancel = 0;
  logic [23:0] time_out = 24'h0;
  logic        set_time, editing;
  logic [23:0] time_in;
  logic [1:0]  edit_field;
  int vectors = 0, miscompares = 0;

  clock_set_controller dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .inc(inc), .dec(dec), .cancel(cancel),
    .time_out(time_out), .set_time(set_time), .time_in(time_in), .editing(editing),
    .edit_field(edit_field)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic m, input logic i, input logic d, input logic c);
    @(negedge clk);
    mode = m; inc = i; dec = d; cancel = c;
    @(posedge clk);
    #1;
    mode = 0; inc = 0; dec = 0; cancel = 0;
  endtask

  task automatic st(input string tag, input logic s, input logic e, input logic [1:0] f, input logic [23:0] t);
    check({tag, ".set_time"}, {23'd0, set_time}, {23'd0, s});
    check({tag, ".editing"}, {23'd0, editing}, {23'd0, e});
    check({tag, ".edit_field"}, {22'd0, edit_field}, {22'd0, f});
    check({tag, ".time_in"}, time_in, t);
  endtask

  initial begin
    #12;
    st("reset", 0, 0, 0, 24'h000000);
    @(negedge clk) reset_n = 1;
    // full edit
    time_out = 24'h123456;
    step(1, 0, 0, 0); st("full_enter", 0, 1, 1, 24'h123456);
    step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
    st("full_hr15", 0, 1, 1, 24'h153456);
    step(1, 0, 0, 0); st("full_min", 0, 1, 2, 24'h153456);
    step(0, 0, 1, 0); st("full_min33", 0, 1, 2, 24'h153356);
    step(1, 0, 0, 0); st("full_sec", 0, 1, 3, 24'h153356);
    step(1, 0, 0, 0); st("full_load", 1, 0, 0, 24'h153356);
    step(0, 0, 0, 0); st("full_run", 0, 0, 0, 24'h153356);
    // hour wrap
    time_out = 24'h235959;
    step(1, 0, 0, 0);
    step(0, 1, 0, 0); st("hr_inc_wrap", 0, 1, 1, 24'h005959);
    step(0, 0, 1, 0); st("hr_dec_wrap", 0, 1, 1, 24'h235959);
    step(0, 0, 1, 0); st("hr_dec", 0, 1, 1, 24'h225959);
    step(0, 0, 0, 1); st("hr_cancel", 0, 0, 0, 24'h225959);
    // minute BCD carry/borrow
    time_out = 24'h080930;
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 1, 0, 0); st("min_carry", 0, 1, 2, 24'h081030);
    step(0, 0, 1, 0); st("min_borrow", 0, 1, 2, 24'h080930);
    step(0, 0, 0, 1);
    time_out = 24'h085900;
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 1, 0, 0); st("min_inc_wrap", 0, 1, 2, 24'h080000);
    step(0, 0, 1, 0); st("min_dec_wrap", 0, 1, 2, 24'h085900);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0); st("sec_dec_wrap", 0, 1, 3, 24'h085959);
    step(0, 1, 0, 0); st("sec_inc_wrap", 0, 1, 3, 24'h085900);
    step(0, 0, 0, 1);
    // cancel mid-edit with inc in the same cycle
    time_out = 24'h111111;
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 1, 0, 1); st("cancel_inc", 0, 0, 0, 24'h111111);
    step(0, 0, 0, 0); st("cancel_after", 0, 0, 0, 24'h111111);
    step(0, 1, 0, 1); st("run_ignore", 0, 0, 0, 24'h111111);
    // priority
    time_out = 24'h050505;
    step(1, 0, 0, 0);
    step(1, 1, 0, 0); st("mode_inc", 0, 1, 2, 24'h050505);
    step(0, 1, 1, 0); st("inc_dec", 0, 1, 2, 24'h050505);
    step(1, 0, 1, 0); st("mode_dec", 0, 1, 3, 24'h050505);
    step(1, 0, 0, 1); st("cancel_mode", 0, 0, 0, 24'h050505);
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(1, 0, 0, 0); st("load2", 1, 0, 0, 24'h050505);
    step(1, 1, 0, 1); st("load_ignore", 0, 0, 0, 24'h050505);
    // async reset mid-cycle in SET_SEC
    time_out = 24'h224411;
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    st("pre_reset", 0, 1, 3, 24'h224411);
    #2 reset_n = 0;
    #1 st("async_reset", 0, 0, 0, 24'h000000);
    mode = 1;
    @(posedge clk); #1;
    st("held_reset", 0, 0, 0, 24'h000000);
    @(negedge clk) reset_n = 1;
    mode = 0;
    time_out = 24'h010203;
    step(1, 0, 0, 0); st("post_reset", 0, 1, 1, 24'h010203);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/clock_set_controller.md
CLOCK_SET_CONTROLLER -- requirements
Module: clock_set_controller

Interface
REQ-001 The block SHALL have the following ports:
- clk  input  1  – system clock; all state updates on the rising edge.
- reset_n  input  1  – asynchronous, active-low reset.
- mode  input  1  – single-cycle pulse; enter edit or advance to the next field.
- inc  input  1  – single-cycle pulse; increment the selected field.
- dec  input  1  – single-cycle pulse; decrement the selected field.
- cancel  input  1  – single-cycle pulse; abandon the edit without loading.
- time_out  input  24  – current BCD time from the 24-hour clock, {hr_t,hr_o,min_t,min_o,sec_t,sec_o}.
- set_time  output  1  – load strobe to the 24-hour clock.
- time_in  output  24  – BCD value to load, same packing as time_out.
- editing  output  1  – high in any SET_* state.
- edit_field  output  2  – selected field: 0=none, 1=hour, 2=minute, 3=second.

Function
REQ-002 The FSM SHALL have exactly five states: RUN, SET_HR, SET_MIN, SET_SEC, LOAD.
REQ-003 In RUN, a mode pulse SHALL do both of the following at the same edge:
- Copy time_out into the 24-bit edit register.
- Move the FSM to SET_HR.
REQ-004 mode SHALL advance the FSM SET_HR→SET_MIN→SET_SEC→LOAD, one state per pulse.
REQ-005 LOAD SHALL last exactly one cycle and then return unconditionally to RUN.
REQ-006 set_time SHALL be 1 only while in LOAD and 0 in all other states.
REQ-007 time_in SHALL always equal the edit register, including in RUN, where it holds the last edited value.
REQ-008 The hour field SHALL be edited as one BCD pair with this range and wrap:
- inc: 00→…→23→00.
- dec: 00→23.
REQ-009 The minute and second fields SHALL each be edited as one BCD pair with this range and wrap:
- inc: 00→…→59→00.
- dec: 00→59.
REQ-010 Increment and decrement SHALL carry and borrow in BCD between the ones and tens digits of a field, never binary (09+1=10, 10-1=09).
REQ-011 A field edit SHALL NOT change any other field; there is no carry into the adjacent field.
REQ-012 inc and dec asserted in the same cycle SHALL leave the edit register unchanged.
REQ-013 inc and dec SHALL be ignored in RUN and in LOAD.
REQ-014 mode asserted in the same cycle as inc or dec SHALL take priority: the FSM advances and the field is not modified.
REQ-015 cancel in any SET_* state SHALL return the FSM to RUN on the next edge without entering LOAD, leaving set_time at 0.
REQ-016 cancel SHALL take priority over mode, inc and dec.
REQ-017 cancel SHALL be ignored in RUN and in LOAD.
REQ-018 The block SHALL NOT alter the edit register on cancel, so time_in keeps the abandoned value while set_time stays 0.
REQ-019 editing SHALL be 1 in SET_HR, SET_MIN and SET_SEC, and 0 in RUN and LOAD.
REQ-020 edit_field SHALL be 1, 2 or 3 in SET_HR, SET_MIN or SET_SEC respectively, and 0 otherwise.
REQ-021 All outputs SHALL be registered or decoded directly from the state register, with no combinational path from inputs to outputs.
REQ-022 Time from a mode pulse in SET_SEC to set_time=1 SHALL be exactly one clock edge.
REQ-023 time_in SHALL be stable during the set_time cycle.

Reset
REQ-024 While reset_n=0, the block SHALL immediately, without waiting for a clock edge, force:
- State = RUN.
- Edit register = 24'h000000.
- set_time = 0, editing = 0, edit_field = 0.
REQ-025 Reset asserted during any SET_* or LOAD state SHALL abort the edit, and no set_time pulse SHALL be emitted.
REQ-026 After reset_n rises, the block SHALL accept mode on the first rising edge.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
- Full edit: time_out=24'h123456; mode; inc×3 (hour 15); mode; dec×1 (minute 33); mode; mode → set_time=1 for one cycle with time_in=24'h153356, then RUN, editing=0.
- Hour wrap: edit hour from 23 with inc → 00; from 00 with dec → 23; minute and second fields unchanged.
- Minute BCD carry: minute 09 inc → 10; 59 inc → 00; 00 dec → 59; hour unchanged.
- Cancel mid-edit: in SET_MIN, cancel with inc in the same cycle → RUN next edge, set_time never 1, edit register unchanged.
- Priority: mode+inc in SET_HR → SET_MIN, hour unchanged; inc+dec together → no change.
- Async reset: reset_n=0 mid-cycle in SET_SEC → outputs reset immediately, no set_time pulse; next mode after release captures time_out.
